// File: rtl/if_id_fetch_stage_if.sv
// Fetch-stage bus bundle: PC-control handshake, instruction-memory port, IF/ID outputs.
// master = fetch stage (drives IF_pc, imem_req/addr, inval_in, halt, ID_*).
// slave  = surroundings (PC control, hazard unit, instruction memory).
interface if_id_fetch_stage_if;
  logic [15:0] pc_next;
  logic [15:0] IF_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic        stall;
  logic        inval_out;
  logic        inval_in;
  logic        halt;
  logic [15:0] ID_instr;
  logic [15:0] ID_pc;
  logic        ID_valid;

  modport master (
    input  pc_next, imem_data, imem_valid, stall, inval_out,
    output IF_pc, imem_req, imem_addr, inval_in, halt, ID_instr, ID_pc, ID_valid
  );

  modport slave (
    output pc_next, imem_data, imem_valid, stall, inval_out,
    input  IF_pc, imem_req, imem_addr, inval_in, halt, ID_instr, ID_pc, ID_valid
  );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Fetch stage + IF/ID register: owns the PC, requests imem, presents {instr, pc, valid} to ID.
// Latency: a word returned in cycle n (no stall) is on ID_instr in cycle n+1; zero-wait memory = 1 instr/cycle.
// Backpressure: stall holds ID and PC; one returning word is parked in a one-entry skid, requests pause until it drains.
// Ports: clk, rst_n (async active-low); fe = master view of if_id_fetch_stage_if
//   (pc_next/IF_pc with PC control, imem_req/addr/data/valid to memory,
//    stall/inval_out/inval_in/halt handshakes, ID_instr/ID_pc/ID_valid to ID).
module if_id_fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OPC = 4'b1111,
  parameter logic [15:0] BUBBLE   = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  if_id_fetch_stage_if.master  fe
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALTED} state_t;

  state_t      state;
  logic [15:0] pc_q;
  logic        skid_full;
  logic [15:0] skid_instr;
  logic [15:0] id_instr_q;
  logic [15:0] id_pc_q;
  logic        id_valid_q;
  logic        inval_q;

  logic        req;
  logic        word_avail;
  logic [15:0] word;
  logic        halt_det;

  // No request while in reset, halted, or while a parked word is waiting.
  assign req        = rst_n && (state != S_HALTED) && !skid_full;
  // The skid entry always belongs to the current pc_q, so it drains ahead of memory.
  assign word_avail = skid_full || (fe.imem_valid && req);
  assign word       = skid_full ? skid_instr : fe.imem_data;
  assign halt_det   = id_valid_q && (id_instr_q[15:12] == HALT_OPC);

  assign fe.IF_pc     = pc_q;
  assign fe.imem_addr = pc_q;
  assign fe.imem_req  = req;
  assign fe.inval_in  = inval_q;
  assign fe.halt      = (state == S_HALTED) || halt_det;
  assign fe.ID_instr  = id_instr_q;
  assign fe.ID_pc     = id_pc_q;
  assign fe.ID_valid  = id_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      pc_q       <= RESET_PC;
      skid_full  <= 1'b0;
      skid_instr <= BUBBLE;
      id_instr_q <= BUBBLE;
      id_pc_q    <= 16'h0000;
      id_valid_q <= 1'b0;
      inval_q    <= 1'b0;
    end else begin
      inval_q <= (state == S_HALTED) ? 1'b0 : fe.inval_out;

      if ((state == S_HALTED) || halt_det) begin
        // A halt word reaching ID freezes the PC where it stands; anything in flight is dropped.
        state      <= S_HALTED;
        skid_full  <= 1'b0;
        id_instr_q <= BUBBLE;
        id_pc_q    <= 16'h0000;
        id_valid_q <= 1'b0;
      end else if (fe.inval_out) begin
        // Squash beats stall: redirect to the branch target and discard any returning word.
        state      <= S_RUN;
        pc_q       <= fe.pc_next;
        skid_full  <= 1'b0;
        id_instr_q <= BUBBLE;
        id_pc_q    <= 16'h0000;
        id_valid_q <= 1'b0;
      end else if (fe.stall) begin
        if (fe.imem_valid && req) begin
          skid_full  <= 1'b1;
          skid_instr <= fe.imem_data;
          state      <= S_RUN;
        end else if (!skid_full) begin
          state      <= S_WAIT;
        end
      end else if (word_avail) begin
        state      <= S_RUN;
        pc_q       <= fe.pc_next;
        skid_full  <= 1'b0;
        id_instr_q <= word;
        id_pc_q    <= pc_q;
        id_valid_q <= 1'b1;
      end else begin
        state      <= S_WAIT;
        id_instr_q <= BUBBLE;
        id_pc_q    <= 16'h0000;
        id_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Bench for if_id_fetch_stage: plays PC control, hazard unit and instruction memory.
// The reference model is the program-order fetch stream: each word reaching ID is
// mem[pc], pcs advance by 2 and jump to the latest squash target; halt words freeze fetch.
module tb_if_id_fetch_stage;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [3:0]  HALT_OPC = 4'b1111;
  localparam logic [15:0] BUBBLE   = 16'h0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_id_fetch_stage_if bus();

  if_id_fetch_stage #(.RESET_PC(RESET_PC), .HALT_OPC(HALT_OPC), .BUBBLE(BUBBLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fe    (bus)
  );

  logic [15:0] mem [0:65535];

  int vectors = 0;
  int miscompares = 0;
  int deliveries = 0;

  // Scoreboard: squash targets queued by stimulus, consumed by the monitor.
  logic [15:0] redir_q [$];
  logic [15:0] exp_pc;
  logic        m_valid;
  logic [15:0] m_pc, m_instr;
  logic        halted_m, halt_pending;
  logic        hold_edge, prev_inval;
  logic        cur_stall, cur_inval;
  logic [15:0] cur_tgt;

  function automatic logic [15:0] fill(input logic [15:0] a);
    return {1'b0, a[14:0] ^ 15'h2A5B};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    redir_q.delete();
    exp_pc       = RESET_PC;
    m_valid      = 1'b0;
    m_pc         = 16'h0000;
    m_instr      = BUBBLE;
    halted_m     = 1'b0;
    halt_pending = 1'b0;
    hold_edge    = 1'b0;
    prev_inval   = 1'b0;
    cur_stall    = 1'b0;
    cur_inval    = 1'b0;
    cur_tgt      = 16'h0000;
  endtask

  task automatic drive_idle();
    bus.imem_valid = 1'b0;
    bus.imem_data  = 16'h0000;
    bus.stall      = 1'b0;
    bus.inval_out  = 1'b0;
    bus.pc_next    = 16'h0000;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_idle();
    clear_model();
    #2;
    chk("rst_IF_pc", bus.IF_pc, RESET_PC);
    chk("rst_ID_instr", bus.ID_instr, BUBBLE);
    chk("rst_ID_pc", bus.ID_pc, 16'h0000);
    chk1("rst_ID_valid", bus.ID_valid, 1'b0);
    chk1("rst_imem_req", bus.imem_req, 1'b0);
    chk1("rst_halt", bus.halt, 1'b0);
    chk1("rst_inval_in", bus.inval_in, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One cycle: account for the edge just taken, then drive this cycle's inputs.
  task automatic step(input logic v, input logic s, input logic i, input logic [15:0] tgt);
    @(posedge clk);
    hold_edge  = cur_stall && !cur_inval && !halted_m && !halt_pending;
    prev_inval = cur_inval && !halted_m;
    if (cur_inval && !halted_m && !halt_pending) redir_q.push_back(cur_tgt);
    if (halt_pending) begin
      halted_m     = 1'b1;
      halt_pending = 1'b0;
    end
    #1;
    cur_stall = s;
    cur_inval = i;
    cur_tgt   = tgt;
    bus.imem_valid = v;
    bus.imem_data  = mem[bus.imem_addr];
    bus.stall      = s;
    bus.inval_out  = i;
    bus.pc_next    = i ? tgt : bus.IF_pc + 16'd2;
  endtask

  // Monitor: checks every ID presentation against the program-order model.
  logic [15:0] mon_w;
  logic        mon_is_halt;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (redir_q.size() > 0) exp_pc = redir_q.pop_front();
        chk1("inval_in", bus.inval_in, prev_inval);
        if (halted_m) begin
          chk1("halted_ID_valid", bus.ID_valid, 1'b0);
          chk1("halted_halt", bus.halt, 1'b1);
          chk1("halted_imem_req", bus.imem_req, 1'b0);
        end else if (hold_edge) begin
          chk1("hold_ID_valid", bus.ID_valid, m_valid);
          if (m_valid) begin
            chk("hold_ID_pc", bus.ID_pc, m_pc);
            chk("hold_ID_instr", bus.ID_instr, m_instr);
          end
          chk1("hold_halt", bus.halt, 1'b0);
        end else if (bus.ID_valid) begin
          mon_w       = mem[exp_pc];
          mon_is_halt = (mon_w[15:12] == HALT_OPC);
          chk("ID_pc", bus.ID_pc, exp_pc);
          chk("ID_instr", bus.ID_instr, mon_w);
          chk1("halt", bus.halt, mon_is_halt);
          if (mon_is_halt) halt_pending = 1'b1;
          m_valid = 1'b1;
          m_pc    = exp_pc;
          m_instr = mon_w;
          exp_pc  = exp_pc + 16'd2;
          deliveries++;
        end else begin
          chk1("bubble_halt", bus.halt, 1'b0);
          m_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  logic        r_v, r_s, r_i;
  logic [15:0] r_t;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = fill(16'(a));
    mem[16'h0000] = 16'h1234;
    mem[16'h0002] = 16'h5678;
    mem[16'h0020] = 16'hA001;
    mem[16'h0040] = 16'hF000;
    mem[16'h0042] = 16'hF042;
    drive_idle();
    clear_model();
    do_reset();

    // Zero-wait stream: one word per cycle, one-cycle latency.
    step(1, 0, 0, 0); #3;
    chk("t1_IF_pc0", bus.IF_pc, 16'h0000);
    chk1("t1_req", bus.imem_req, 1'b1);
    chk("t1_addr", bus.imem_addr, 16'h0000);
    step(1, 0, 0, 0); #3;
    chk1("t1_valid1", bus.ID_valid, 1'b1);
    chk("t1_instr1", bus.ID_instr, 16'h1234);
    chk("t1_pc1", bus.ID_pc, 16'h0000);
    step(0, 0, 0, 0); #3;
    chk1("t1_valid2", bus.ID_valid, 1'b1);
    chk("t1_instr2", bus.ID_instr, 16'h5678);
    chk("t1_pc2", bus.ID_pc, 16'h0002);

    // Memory wait: three bubbles with the PC parked.
    step(0, 0, 1, 16'h0010);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0); #3;
      chk1("t2_bubble", bus.ID_valid, 1'b0);
      chk("t2_pc_stable", bus.IF_pc, 16'h0010);
    end
    step(1, 0, 0, 0); #3;
    chk("t2_pc_ret", bus.IF_pc, 16'h0010);
    step(0, 0, 0, 0); #3;
    chk1("t2_valid", bus.ID_valid, 1'b1);
    chk("t2_pc", bus.ID_pc, 16'h0010);
    chk("t2_instr", bus.ID_instr, fill(16'h0010));

    // Stall with a returning word: skid captures, requests pause, drains on release.
    step(0, 0, 1, 16'h0020);
    step(1, 1, 0, 0); #3;
    chk1("t3_req_a", bus.imem_req, 1'b1);
    chk("t3_pc_a", bus.IF_pc, 16'h0020);
    step(0, 1, 0, 0); #3;
    chk1("t3_req_b", bus.imem_req, 1'b0);
    chk1("t3_held", bus.ID_valid, 1'b0);
    chk("t3_pc_b", bus.IF_pc, 16'h0020);
    step(0, 0, 0, 0); #3;
    chk1("t3_req_c", bus.imem_req, 1'b0);
    step(0, 0, 0, 0); #3;
    chk1("t3_valid", bus.ID_valid, 1'b1);
    chk("t3_instr", bus.ID_instr, 16'hA001);
    chk("t3_pc", bus.ID_pc, 16'h0020);
    chk("t3_next_pc", bus.IF_pc, 16'h0022);

    // Squash while stalled with a full skid.
    step(0, 0, 1, 16'h0030);
    step(1, 1, 0, 0);
    step(0, 1, 1, 16'h0100); #3;
    chk1("t4_skid_full", bus.imem_req, 1'b0);
    step(0, 0, 0, 0); #3;
    chk1("t4_bubble", bus.ID_valid, 1'b0);
    chk("t4_addr", bus.imem_addr, 16'h0100);
    chk1("t4_req", bus.imem_req, 1'b1);
    chk1("t4_inval_in1", bus.inval_in, 1'b1);
    step(1, 0, 0, 0); #3;
    chk1("t4_inval_in0", bus.inval_in, 1'b0);
    step(0, 0, 0, 0); #3;
    chk("t4_target", bus.ID_pc, 16'h0100);

    // Halt word reaches ID.
    step(0, 0, 1, 16'h0040);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); #3;
    chk1("t5_halt", bus.halt, 1'b1);
    chk("t5_instr", bus.ID_instr, 16'hF000);
    chk("t5_pc", bus.IF_pc, 16'h0042);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0); #3;
      chk1("t5_halt_hold", bus.halt, 1'b1);
      chk1("t5_req", bus.imem_req, 1'b0);
      chk("t5_frozen", bus.IF_pc, 16'h0042);
    end
    step(1, 0, 1, 16'h0300);
    step(0, 0, 0, 0); #3;
    chk1("t5_no_inval", bus.inval_in, 1'b0);
    chk("t5_still_frozen", bus.IF_pc, 16'h0042);
    do_reset();

    // Halt word squashed on return never halts.
    step(0, 0, 1, 16'h0042);
    step(0, 0, 0, 0);
    step(1, 0, 1, 16'h0200);
    step(1, 0, 0, 0); #3;
    chk1("t6_no_halt", bus.halt, 1'b0);
    chk1("t6_bubble", bus.ID_valid, 1'b0);
    chk("t6_target", bus.IF_pc, 16'h0200);
    step(0, 0, 0, 0); #3;
    chk("t6_pc", bus.ID_pc, 16'h0200);
    chk1("t6_no_halt2", bus.halt, 1'b0);

    // PC wrap at 16 bits.
    step(0, 0, 1, 16'hFFFE);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); #3;
    chk("t7_pc_ffe", bus.ID_pc, 16'hFFFE);
    chk("t7_wrap", bus.IF_pc, 16'h0000);
    step(0, 0, 0, 0); #3;
    chk("t7_pc0", bus.ID_pc, 16'h0000);
    chk("t7_instr0", bus.ID_instr, 16'h1234);

    // Randomized traffic; no halt words reachable.
    mem[16'h0040] = fill(16'h0040);
    mem[16'h0042] = fill(16'h0042);
    r_i = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        do_reset();
        r_i = 1'b0;
      end
      r_v = ($urandom_range(0, 99) < 60);
      r_s = ($urandom_range(0, 99) < 25);
      r_i = !r_i && ($urandom_range(0, 99) < 7);
      r_t = 16'($urandom_range(2048, 16383)) << 1;
      step(r_v, r_s, r_i, r_t);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    #3;
    chk1("throughput", deliveries >= 150, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
